// File: rtl/hv_assoc_search.sv
// rtl/hv_assoc_search.sv - Hamming-distance associative search over class hypervectors
// Buffers one query, scans every class frame by frame, reports the nearest class.
module hv_assoc_search #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2,
    parameter int DIST_W             = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          q_valid,
    output logic                          q_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] q_data,
    output logic [CLASS_ID_W-1:0]         frame_id,
    output logic [FRAME_IDX_W-1:0]        frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CLASS_ID_W-1:0]         res_class,
    output logic [DIST_W-1:0]             res_dist,
    output logic                          busy
);

    typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

    state_t                          r_state, w_next;
    logic [FRAME_IDX_W-1:0]          r_load_cnt, r_frm;
    logic [CLASS_ID_W-1:0]           r_cls, r_best_id, r_res_class;
    logic [DIST_W-1:0]               r_acc, r_best_dist, r_res_dist;
    logic [DI_PARALLEL_W_BITS-1:0]   r_buf [NUM_FRAMES];

    logic                            w_load_fire, w_load_last, w_frm_last, w_cls_last, w_take;
    logic [DI_PARALLEL_W_BITS-1:0]   w_diff;
    logic [DIST_W-1:0]               w_dist, w_tot, w_best_dist_n;
    logic [CLASS_ID_W-1:0]           w_best_id_n;

    assign w_load_fire = (r_state == LOAD) && q_valid;
    assign w_load_last = (r_load_cnt == FRAME_IDX_W'(NUM_FRAMES - 1));
    assign w_frm_last  = (r_frm == FRAME_IDX_W'(NUM_FRAMES - 1));
    assign w_cls_last  = (r_cls == CLASS_ID_W'(NUM_CLASSES - 1));

    always_comb begin
        w_diff = r_buf[r_frm] ^ class_vec_in;
        w_dist = '0;
        for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
            w_dist = w_dist + DIST_W'(w_diff[i]);
        end
    end

    // Strict compare keeps the lower class id on ties; class 0 always seeds the best.
    assign w_tot         = r_acc + w_dist;
    assign w_take        = (r_cls == '0) || (w_tot < r_best_dist);
    assign w_best_dist_n = w_take ? w_tot : r_best_dist;
    assign w_best_id_n   = w_take ? r_cls : r_best_id;

    always_ff @(posedge clk) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (w_load_fire && w_load_last) w_next = SEARCH;
            SEARCH:  if (w_frm_last && w_cls_last)   w_next = DONE;
            DONE:    if (res_ready)                  w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_load_fire) r_buf[r_load_cnt] <= q_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt  <= '0;
            r_cls       <= '0;
            r_frm       <= '0;
            r_acc       <= '0;
            r_best_dist <= '1;
            r_best_id   <= '0;
            r_res_class <= '0;
            r_res_dist  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_load_fire) begin
                        if (w_load_last) begin
                            r_load_cnt  <= '0;
                            r_cls       <= '0;
                            r_frm       <= '0;
                            r_acc       <= '0;
                            r_best_dist <= '1;
                            r_best_id   <= '0;
                        end else begin
                            r_load_cnt  <= r_load_cnt + 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (!w_frm_last) begin
                        r_acc <= w_tot;
                        r_frm <= r_frm + 1'b1;
                    end else begin
                        r_best_dist <= w_best_dist_n;
                        r_best_id   <= w_best_id_n;
                        r_acc       <= '0;
                        r_frm       <= '0;
                        // Clearing cls on the final frame parks the generator address at 0.
                        if (w_cls_last) begin
                            r_cls       <= '0;
                            r_res_class <= w_best_id_n;
                            r_res_dist  <= w_best_dist_n;
                        end else begin
                            r_cls       <= r_cls + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_ready     = (r_state == LOAD);
    assign res_valid   = (r_state == DONE);
    assign busy        = (r_state != LOAD);
    assign frame_id    = r_cls;
    assign frame_index = r_frm;
    assign res_class   = r_res_class;
    assign res_dist    = r_res_dist;

endmodule
